cpu_data_path: RTL and testbench

- Single-bus 32-bit CPU datapath (the `data_path` DUT).
- Contains 16 general registers plus HI, LO, Z (64-bit, split high/low), PC, IR, MAR, MDR, InPort and Y, together with an ALU.
- A one-hot "out" control set selects which register drives the shared bus. "in" enables load registers on the rising clock edge.
- The control unit, or a bench FSM, sequences the T-states.

---
 rtl/cpu_data_path_pkg.sv | 27 ++
 rtl/cpu_data_path_if.sv | 36 +++
 rtl/cpu_data_path_reg32.sv | 22 ++
 rtl/cpu_data_path.sv | 98 +++++++++
 tb/tb_cpu_data_path.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_data_path_pkg.sv
// Shared constants for the single-bus CPU datapath: bus width, ALU function
// codes and the bus-source numbering (lower index wins the bus).
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_NEG = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_INC = 3'd6;
    localparam logic [2:0] ALU_MUL = 3'd7;

    // R0..R15 occupy indices 0..15.
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_Y      = 23;
    localparam int NUM_SRC    = 24;

endpackage

// File: rtl/cpu_data_path_if.sv
// Control and data bundle between the sequencer (master) and the datapath
// (slave). Rout/Rin bit i is the out-select / load-enable of general register Ri.
interface cpu_data_path_if;
    import cpu_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] RegisterAImmediate;
    logic [WIDTH-1:0] MDataIn;
    logic [15:0]      Rout;
    logic [15:0]      Rin;
    logic             HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
    logic             HIin, LOin, PCin, IRin, MARin, MDRin, InPortin, Yin;
    logic             Zhighin, Zlowin;
    logic             Read;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] busOut;
    logic [WIDTH-1:0] IRq;
    logic [WIDTH-1:0] MARq;

    modport master (
        output A, RegisterAImmediate, MDataIn, Rout, Rin,
        output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
        output HIin, LOin, PCin, IRin, MARin, MDRin, InPortin, Yin,
        output Zhighin, Zlowin, Read, ALUop,
        input  busOut, IRq, MARq
    );

    modport slave (
        input  A, RegisterAImmediate, MDataIn, Rout, Rin,
        input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
        input  HIin, LOin, PCin, IRin, MARin, MDRin, InPortin, Yin,
        input  Zhighin, Zlowin, Read, ALUop,
        output busOut, IRq, MARq
    );

endinterface

// File: rtl/cpu_data_path_reg32.sv
// Datapath register: asynchronous active-low clear, synchronous load enable.
module reg32
    import cpu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_data_path.sv
// Single-bus 32-bit CPU datapath: priority-encoded shared bus, bus-sourced
// registers, 64-bit Z pair fed by a combinational ALU. Sequencing is external.
module cpu_data_path
    import cpu_pkg::*;
(
    input logic            clock,
    input logic            clear,
    cpu_data_path_if.slave dp
);

    logic [WIDTH-1:0]   src_q [NUM_SRC];
    logic [WIDTH-1:0]   src_d [NUM_SRC];
    logic [NUM_SRC-1:0] out_sel;
    logic [NUM_SRC-1:0] in_en;
    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   ir_q;
    logic [WIDTH-1:0]   mar_q;
    logic [2*WIDTH-1:0] y_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] alu_c;

    assign out_sel = {dp.Yout, dp.InPortout, dp.MDRout, dp.PCout,
                      dp.Zlowout, dp.Zhighout, dp.LOout, dp.HIout, dp.Rout};
    assign in_en   = {dp.Yin, dp.InPortin, dp.MDRin, dp.PCin,
                      dp.Zlowin, dp.Zhighin, dp.LOin, dp.HIin, dp.Rin};

    // Scan from the lowest-priority source up so the lowest index wins.
    always_comb begin
        bus = dp.RegisterAImmediate;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (out_sel[i]) begin
                bus = src_q[i];
            end
        end
    end

    assign y_q   = src_q[SRC_Y];
    assign y_ext = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    assign b_ext = {{WIDTH{bus[WIDTH-1]}}, bus};

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    always_comb begin
        alu_c = '0;
        case (dp.ALUop)
            ALU_AND: alu_c = {{WIDTH{1'b0}}, y_q & bus};
            ALU_OR:  alu_c = {{WIDTH{1'b0}}, y_q | bus};
            ALU_ADD: alu_c = {{WIDTH{1'b0}}, y_q + bus};
            ALU_SUB: alu_c = {{WIDTH{1'b0}}, y_q - bus};
            ALU_NEG: alu_c = {{WIDTH{1'b0}}, {WIDTH{1'b0}} - bus};
            ALU_NOT: alu_c = {{WIDTH{1'b0}}, ~bus};
            ALU_INC: alu_c = {{WIDTH{1'b0}}, bus + WIDTH'(1)};
            ALU_MUL: alu_c = y_ext * b_ext;
            default: alu_c = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_d[i] = bus;
        end
        src_d[SRC_ZHI]    = alu_c[2*WIDTH-1:WIDTH];
        src_d[SRC_ZLO]    = alu_c[WIDTH-1:0];
        src_d[SRC_MDR]    = dp.Read ? dp.MDataIn : bus;
        src_d[SRC_INPORT] = dp.A;
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_reg
        reg32 #(.W(WIDTH)) u_reg (
            .clock (clock),
            .clear (clear),
            .en    (in_en[g]),
            .d     (src_d[g]),
            .q     (src_q[g])
        );
    end

    reg32 #(.W(WIDTH)) u_ir (
        .clock (clock),
        .clear (clear),
        .en    (dp.IRin),
        .d     (bus),
        .q     (ir_q)
    );

    reg32 #(.W(WIDTH)) u_mar (
        .clock (clock),
        .clear (clear),
        .en    (dp.MARin),
        .d     (bus),
        .q     (mar_q)
    );

    assign dp.busOut = bus;
    assign dp.IRq    = ir_q;
    assign dp.MARq   = mar_q;

endmodule

// File: tb/tb_cpu_data_path.sv
// Bench for cpu_data_path: directed T-state vectors, bus priority and reset
// sequences, then random cycles against a register-array reference model.
module tb_cpu_data_path;
    import cpu_pkg::*;

    localparam int IN_IR  = 24;
    localparam int IN_MAR = 25;
    localparam int NUM_IN = 26;

    typedef struct {
        string               name;
        logic [NUM_SRC-1:0]  outs;
        logic [NUM_IN-1:0]   ins;
        logic                read;
        logic [2:0]          op;
        logic [31:0]         mdata;
        logic [31:0]         a;
        logic [31:0]         imm;
        int                  probe;
        logic [31:0]         exp;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    logic [31:0] exp_q[$];
    vec_t tbl[$];
    logic [31:0] m [NUM_IN];

    cpu_data_path_if dp();

    cpu_data_path dut (
        .clock (clock),
        .clear (clear),
        .dp    (dp)
    );

    always #5 clock = ~clock;

    function automatic logic [NUM_SRC-1:0] o_(input int i);
        logic [NUM_SRC-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_IN-1:0] i_(input int i);
        logic [NUM_IN-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input string name, input logic [NUM_SRC-1:0] outs,
                                input logic [NUM_IN-1:0] ins, input logic read,
                                input logic [2:0] op, input logic [31:0] mdata,
                                input logic [31:0] a, input logic [31:0] imm,
                                input int probe, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.outs = outs; v.ins = ins; v.read = read; v.op = op;
        v.mdata = mdata; v.a = a; v.imm = imm; v.probe = probe; v.exp = exp;
        return v;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [2:0] op, input logic [31:0] y,
                                            input logic [31:0] b);
        int     ys;
        int     bs;
        longint p;
        ys = y;
        bs = b;
        p  = longint'(ys) * longint'(bs);
        case (op)
            ALU_AND: return {32'h0, y & b};
            ALU_OR:  return {32'h0, y | b};
            ALU_ADD: return {32'h0, y + b};
            ALU_SUB: return {32'h0, y - b};
            ALU_NEG: return {32'h0, 32'h0 - b};
            ALU_NOT: return {32'h0, ~b};
            ALU_INC: return {32'h0, b + 32'd1};
            default: return 64'(p);
        endcase
    endfunction

    task automatic drive(input logic [NUM_SRC-1:0] outs, input logic [NUM_IN-1:0] ins,
                         input logic read, input logic [2:0] op, input logic [31:0] mdata,
                         input logic [31:0] a, input logic [31:0] imm);
        dp.Rout      = outs[15:0];
        dp.HIout     = outs[SRC_HI];
        dp.LOout     = outs[SRC_LO];
        dp.Zhighout  = outs[SRC_ZHI];
        dp.Zlowout   = outs[SRC_ZLO];
        dp.PCout     = outs[SRC_PC];
        dp.MDRout    = outs[SRC_MDR];
        dp.InPortout = outs[SRC_INPORT];
        dp.Yout      = outs[SRC_Y];
        dp.Rin       = ins[15:0];
        dp.HIin      = ins[SRC_HI];
        dp.LOin      = ins[SRC_LO];
        dp.Zhighin   = ins[SRC_ZHI];
        dp.Zlowin    = ins[SRC_ZLO];
        dp.PCin      = ins[SRC_PC];
        dp.MDRin     = ins[SRC_MDR];
        dp.InPortin  = ins[SRC_INPORT];
        dp.Yin       = ins[SRC_Y];
        dp.IRin      = ins[IN_IR];
        dp.MARin     = ins[IN_MAR];
        dp.Read      = read;
        dp.ALUop     = op;
        dp.MDataIn   = mdata;
        dp.A         = a;
        dp.RegisterAImmediate = imm;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Observe one register without a clock edge: IR/MAR via their ports, others via the bus.
    task automatic probe(input string name, input int p, input logic [31:0] exp);
        if (p < NUM_SRC) drive(o_(p), '0, 1'b0, ALU_AND, 32'h0, 32'h0, 32'h0);
        else             drive('0, '0, 1'b0, ALU_AND, 32'h0, 32'h0, 32'h0);
        #1;
        if (p == IN_IR)       check(name, dp.IRq, exp);
        else if (p == IN_MAR) check(name, dp.MARq, exp);
        else                  check(name, dp.busOut, exp);
    endtask

    task automatic check_all_zero(input string name);
        for (int p = 0; p < NUM_IN; p++) begin
            probe($sformatf("%s_%0d", name, p), p, 32'h0);
        end
    endtask

    task automatic step(input vec_t v);
        drive(v.outs, v.ins, v.read, v.op, v.mdata, v.a, v.imm);
        @(posedge clock);
        #1;
        probe(v.name, v.probe, v.exp);
    endtask

    initial begin
        logic [NUM_SRC-1:0] outs;
        logic [NUM_IN-1:0]  ins;
        logic               read;
        logic [2:0]         op;
        logic [31:0]        mdata, a, imm, mbus;
        logic [63:0]        c;
        logic [31:0]        nm [NUM_IN];
        int                 r, p;

        drive('0, '0, 1'b0, ALU_AND, 32'h0, 32'h0, 32'h0);
        #3;
        check_all_zero("reset0");
        clear = 1'b1;

        tbl.push_back(mk("mdr_12",      '0, i_(SRC_MDR), 1, ALU_AND, 32'h12, 0, 0, SRC_MDR, 32'h12));
        tbl.push_back(mk("r2_load",     o_(SRC_MDR), i_(2), 0, ALU_AND, 0, 0, 0, 2, 32'h12));
        tbl.push_back(mk("mdr_14",      '0, i_(SRC_MDR), 1, ALU_AND, 32'h14, 0, 0, SRC_MDR, 32'h14));
        tbl.push_back(mk("r3_load",     o_(SRC_MDR), i_(3), 0, ALU_AND, 0, 0, 0, 3, 32'h14));
        tbl.push_back(mk("mdr_18",      '0, i_(SRC_MDR), 1, ALU_AND, 32'h18, 0, 0, SRC_MDR, 32'h18));
        tbl.push_back(mk("r1_load",     o_(SRC_MDR), i_(1), 0, ALU_AND, 0, 0, 0, 1, 32'h18));
        tbl.push_back(mk("y_from_r2",   o_(2), i_(SRC_Y), 0, ALU_AND, 0, 0, 0, SRC_Y, 32'h12));
        tbl.push_back(mk("and_zlo",     o_(3), i_(SRC_ZHI) | i_(SRC_ZLO), 0, ALU_AND, 0, 0, 0, SRC_ZLO, 32'h10));
        tbl.push_back(mk("and_zhi",     '0, '0, 0, ALU_AND, 0, 0, 0, SRC_ZHI, 32'h0));
        tbl.push_back(mk("r1_from_zlo", o_(SRC_ZLO), i_(1), 0, ALU_AND, 0, 0, 0, 1, 32'h10));
        tbl.push_back(mk("fetch_mar",   o_(SRC_PC), i_(IN_MAR) | i_(SRC_ZLO), 0, ALU_INC, 0, 0, 0, IN_MAR, 32'h0));
        tbl.push_back(mk("fetch_zlo",   '0, '0, 0, ALU_AND, 0, 0, 0, SRC_ZLO, 32'h1));
        tbl.push_back(mk("fetch_pc",    o_(SRC_ZLO), i_(SRC_PC) | i_(SRC_MDR), 1, ALU_AND, 32'h28918000, 0, 0, SRC_PC, 32'h1));
        tbl.push_back(mk("fetch_mdr",   '0, '0, 0, ALU_AND, 0, 0, 0, SRC_MDR, 32'h28918000));
        tbl.push_back(mk("fetch_ir",    o_(SRC_MDR), i_(IN_IR), 0, ALU_AND, 0, 0, 0, IN_IR, 32'h28918000));
        tbl.push_back(mk("y_ones",      '0, i_(SRC_Y), 0, ALU_AND, 0, 0, 32'hFFFFFFFF, SRC_Y, 32'hFFFFFFFF));
        tbl.push_back(mk("r4_two",      '0, i_(4), 0, ALU_AND, 0, 0, 32'h2, 4, 32'h2));
        tbl.push_back(mk("mul_zhi",     o_(4), i_(SRC_ZHI) | i_(SRC_ZLO), 0, ALU_MUL, 0, 0, 0, SRC_ZHI, 32'hFFFFFFFF));
        tbl.push_back(mk("mul_zlo",     '0, '0, 0, ALU_AND, 0, 0, 0, SRC_ZLO, 32'hFFFFFFFE));
        tbl.push_back(mk("y_five",      '0, i_(SRC_Y), 0, ALU_AND, 0, 0, 32'h5, SRC_Y, 32'h5));
        tbl.push_back(mk("sub_zlo",     '0, i_(SRC_ZHI) | i_(SRC_ZLO), 0, ALU_SUB, 0, 0, 32'h7, SRC_ZLO, 32'hFFFFFFFE));
        tbl.push_back(mk("sub_zhi",     '0, '0, 0, ALU_AND, 0, 0, 0, SRC_ZHI, 32'h0));
        tbl.push_back(mk("or_zlo",      '0, i_(SRC_ZLO), 0, ALU_OR, 0, 0, 32'h0A, SRC_ZLO, 32'h0F));
        tbl.push_back(mk("add_wrap",    '0, i_(SRC_ZLO), 0, ALU_ADD, 0, 0, 32'hFFFFFFFE, SRC_ZLO, 32'h3));
        tbl.push_back(mk("neg_zlo",     '0, i_(SRC_ZLO), 0, ALU_NEG, 0, 0, 32'h3, SRC_ZLO, 32'hFFFFFFFD));
        tbl.push_back(mk("not_zlo",     '0, i_(SRC_ZLO), 0, ALU_NOT, 0, 0, 32'h0F0F0F0F, SRC_ZLO, 32'hF0F0F0F0));
        tbl.push_back(mk("r4_self",     o_(4), i_(4), 0, ALU_AND, 0, 0, 32'h99, 4, 32'h2));
        tbl.push_back(mk("inport",      '0, i_(SRC_INPORT), 0, ALU_AND, 0, 32'h55, 0, SRC_INPORT, 32'h55));
        tbl.push_back(mk("r5_load",     '0, i_(5), 0, ALU_AND, 0, 0, 32'hAAAA0005, 5, 32'hAAAA0005));
        tbl.push_back(mk("hi_lo",       '0, i_(SRC_HI) | i_(SRC_LO), 0, ALU_AND, 0, 0, 32'h1234, SRC_LO, 32'h1234));

        foreach (tbl[k]) step(tbl[k]);

        // Bus priority and idle bus, combinational only.
        drive(o_(5) | o_(SRC_PC), '0, 0, ALU_AND, 0, 0, 32'h0);
        #1 check("prio_r5_pc", dp.busOut, 32'hAAAA0005);
        drive(o_(SRC_HI) | o_(SRC_Y), '0, 0, ALU_AND, 0, 0, 32'h0);
        #1 check("prio_hi_y", dp.busOut, 32'h1234);
        drive(o_(15) | o_(SRC_HI), '0, 0, ALU_AND, 0, 0, 32'h0);
        #1 check("prio_r15_hi", dp.busOut, 32'h0);
        drive('0, '0, 0, ALU_AND, 0, 0, 32'hDEADBEEF);
        #1 check("idle_imm", dp.busOut, 32'hDEADBEEF);
        drive(o_(SRC_INPORT), '0, 0, ALU_AND, 0, 0, 32'hDEADBEEF);
        #1 check("inport_out", dp.busOut, 32'h55);

        // Asynchronous clear between edges, loads blocked while low, resume after.
        @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check_all_zero("async_clr");
        drive('0, i_(6), 0, ALU_AND, 0, 0, 32'h77);
        @(posedge clock);
        #1;
        probe("load_in_clear", 6, 32'h0);
        clear = 1'b1;
        drive('0, i_(6), 0, ALU_AND, 0, 0, 32'h77);
        @(posedge clock);
        #1;
        probe("load_after_clear", 6, 32'h77);

        // Random cycles against the reference model.
        @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        clear = 1'b1;
        for (int k = 0; k < NUM_IN; k++) m[k] = 32'h0;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            outs = '0;
            if (r >= 3) outs = o_($urandom_range(0, NUM_SRC - 1));
            if (r >= 7) outs = outs | o_($urandom_range(0, NUM_SRC - 1));
            ins = i_($urandom_range(0, NUM_IN - 1));
            if ($urandom_range(0, 1) == 1) ins = ins | i_($urandom_range(0, NUM_IN - 1));
            read  = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            mdata = $urandom;
            a     = $urandom;
            imm   = $urandom;

            mbus = imm;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (outs[k]) begin
                    mbus = m[k];
                    break;
                end
            end
            c  = alu_ref(op, m[SRC_Y], mbus);
            nm = m;
            for (int k = 0; k < NUM_IN; k++) begin
                if (ins[k]) begin
                    if (k == SRC_MDR)         nm[k] = read ? mdata : mbus;
                    else if (k == SRC_INPORT) nm[k] = a;
                    else if (k == SRC_ZHI)    nm[k] = c[63:32];
                    else if (k == SRC_ZLO)    nm[k] = c[31:0];
                    else                      nm[k] = mbus;
                end
            end

            drive(outs, ins, read, op, mdata, a, imm);
            #1 check("rand_bus", dp.busOut, mbus);
            m = nm;
            @(posedge clock);
            #1;
            p = $urandom_range(0, NUM_IN - 1);
            exp_q.push_back(m[p]);
            probe($sformatf("rand_reg%0d", p), p, exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
